// File: rtl/pcs_64b66b_pkg.sv
// pcs_64b66b_pkg: shared 64b/66b PCS constants, FSM state and block-type encodings
package pcs_64b66b_pkg;
  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_E, TX_T} tx_state_e;
  typedef enum logic [2:0] {TT_S, TT_C, TT_E, TT_D, TT_T} t_type_e;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [7:0] BT_C = 8'h1E;
  localparam logic [7:0] BT_S = 8'h78;
  localparam logic [7:0] BT_O = 8'h4B;
  localparam logic [63:0] BT_T = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};
  localparam logic [7:0] CH_IDLE = 8'h07;
  localparam logic [7:0] CH_ERR = 8'hFE;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM = 8'hFD;
  localparam logic [7:0] CH_SEQ = 8'h9C;
  localparam logic [6:0] C7_IDLE = 7'h00;
  localparam logic [6:0] C7_ERR = 7'h1E;
  localparam logic [3:0] O_SEQ = 4'h0;
  localparam logic [71:0] IDLE_WORD = {{8{CH_IDLE}}, 8'hFF};
  localparam logic [65:0] EBLOCK_T = {{8{C7_ERR}}, BT_C, SYNC_CTRL};
  localparam logic [65:0] LBLOCK_T = {28'h0, O_SEQ, 8'h01, 8'h00, 8'h00, BT_O, SYNC_CTRL};
endpackage

// File: rtl/t_type_classify.sv
// t_type_classify: classify an XLGMII word as S/C/E/D/T and report the terminate position k
//   word   in  72  [71:8] bytes, [7:0] control flags
//   t_type out 3   block class
//   k      out 3   FD byte position when t_type is T
module t_type_classify
  import pcs_64b66b_pkg::*;
(
  input  logic [71:0] word,
  output t_type_e     t_type,
  output logic [2:0]  k
);
  logic [7:0] ctrl, idle_at, fd_at, hi;
  logic t_hit;
  assign ctrl = word[7:0];
  always_comb begin
    idle_at = '0;
    fd_at = '0;
    hi = '0;
    t_hit = 1'b0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      idle_at[i] = word[8*i+8 +: 8] == CH_IDLE;
      fd_at[i] = word[8*i+8 +: 8] == CH_TERM;
    end
    // ctrl patterns FF<<i are mutually exclusive, so at most one k can match
    for (int i = 0; i < 8; i++) begin
      hi = 8'hFF << (i + 1);
      if (ctrl == 8'(8'hFF << i) && fd_at[i] && &(idle_at | ~hi)) begin
        t_hit = 1'b1;
        k = 3'(i);
      end
    end
    t_type = ctrl == 8'h00 ? TT_D :
             ctrl == 8'h01 && word[15:8] == CH_START ? TT_S :
             (ctrl == 8'hFF && &idle_at) || (ctrl == 8'h01 && word[15:8] == CH_SEQ) ? TT_C :
             t_hit ? TT_T : TT_E;
  end
endmodule

// File: rtl/pcs_tx_encoder.sv
// pcs_tx_encoder: 64b/66b PCS transmit encoder, XLGMII 72-bit words to 66-bit blocks
//   RX_CLK                 in  1     clock
//   reset                  in  1     asynchronous, active-low
//   tx_enable              in  1     0 forces the FSM to TX_INIT (local fault output)
//   encoder_in             in  72    [71:8] bytes, [7:0] control flags
//   encoder_out            out 66    [1:0] sync, [65:2] payload
//   tx_errored_block_count out CNT_W saturating count of cycles spent in TX_E
module pcs_tx_encoder
  import pcs_64b66b_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic             RX_CLK,
  input  logic             reset,
  input  logic             tx_enable,
  input  logic [71:0]      encoder_in,
  output logic [65:0]      encoder_out,
  output logic [CNT_W-1:0] tx_errored_block_count
);
  logic [71:0] in_buf;
  logic [65:0] out_next;
  logic [2:0] k;
  t_type_e t_type;
  tx_state_e state, next_state;
  t_type_classify u_classify (.word(in_buf), .t_type(t_type), .k(k));
  function automatic logic [65:0] encode(input logic [71:0] w, input t_type_e tt, input logic [2:0] tk);
    logic [55:0] mask;
    // keeps only the tk data bytes of a terminate block; a shift of 56 yields all ones
    mask = ~(56'hFF_FFFF_FFFF_FFFF << {tk, 3'b000});
    return tt == TT_D ? {w[71:8], SYNC_DATA} :
           tt == TT_S ? {w[71:16], BT_S, SYNC_CTRL} :
           tt == TT_T ? {w[63:8] & mask, BT_T[8*tk +: 8], SYNC_CTRL} :
           w[7:0] == 8'h01 ? {28'h0, O_SEQ, w[39:16], BT_O, SYNC_CTRL} :
           {{8{C7_IDLE}}, BT_C, SYNC_CTRL};
  endfunction
  always_comb begin
    next_state = !tx_enable ? TX_INIT :
                 state == TX_D ? (t_type == TT_D ? TX_D : t_type == TT_T ? TX_T : TX_E) :
                 state == TX_E ? (t_type == TT_D ? TX_D : t_type == TT_C ? TX_C :
                                  t_type == TT_T ? TX_T : TX_E) :
                 t_type == TT_C ? TX_C : t_type == TT_S ? TX_D : TX_E;
    out_next = next_state == TX_INIT ? LBLOCK_T :
               next_state == TX_E ? EBLOCK_T : encode(in_buf, t_type, k);
  end
  always_ff @(posedge RX_CLK or negedge reset) begin
    if (!reset) begin
      state <= TX_INIT;
      in_buf <= IDLE_WORD;
      encoder_out <= LBLOCK_T;
      tx_errored_block_count <= '0;
    end else begin
      state <= next_state;
      in_buf <= encoder_in;
      encoder_out <= out_next;
      if (state == TX_E && !(&tx_errored_block_count))
        tx_errored_block_count <= tx_errored_block_count + 1'b1;
    end
  end
endmodule
